mem_access_unit: RTL and testbench

- Initiator side of the single-port byte-addressed data RAM: accepts load/store requests from the core's execute stage and drives the RAM word port.
- RAM word layout is big-endian: the byte at address A maps to bits [31:24], A+1 to [23:16], A+2 to [15:8], A+3 to [7:0].
- The RAM only writes whole words, so byte and halfword stores use read-modify-write.
- Loads return sign- or zero-extended results over a valid/ready response channel.

---
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-wide data RAM.
// Sub-word stores use read-modify-write; loads are extended.
module mem_access_unit #(
    parameter int MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_ce,
    output logic        mem_data_le,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, LOAD, RMW_RD, WRITE, RESP
    } state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic        acc_err;
    logic [32:0] word_end;

    // Select the addressed lane (big-endian) and extend it.
    function automatic logic [31:0] extract(
        input logic [31:0] w,
        input logic [1:0]  k,
        input logic [1:0]  sz,
        input logic        u
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        unique case (k)
            2'd0: b = w[31:24];
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            default: b = w[7:0];
        endcase
        h = k[1] ? w[15:0] : w[31:16];
        unique case (sz)
            2'b00: r = u ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01: r = u ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Overlay the store lane(s) onto the old word.
    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [15:0] wd,
        input logic [1:0]  k,
        input logic [1:0]  sz
    );
        logic [31:0] r;
        r = old;
        if (sz == 2'b00) begin
            unique case (k)
                2'd0: r[31:24] = wd[7:0];
                2'd1: r[23:16] = wd[7:0];
                2'd2: r[15:8]  = wd[7:0];
                default: r[7:0] = wd[7:0];
            endcase
        end else if (k[1]) begin
            r[15:0] = wd;
        end else begin
            r[31:16] = wd;
        end
        return r;
    endfunction

    // Classify the incoming request as legal or not.
    always_comb begin
        word_end = {1'b0, req_addr[31:2], 2'b00} + 33'd4;
        unique case (req_size)
            2'b00: acc_err = 1'b0;
            2'b01: acc_err = req_addr[0];
            2'b10: acc_err = |req_addr[1:0];
            default: acc_err = 1'b1;
        endcase
        if (word_end > 33'(MEM_BYTES))
            acc_err = 1'b1;
    end

    // Request/response FSM with registered datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 16'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata[15:0];
                        rsp_rdata <= 32'h0;
                        rsp_err   <= acc_err;
                        if (acc_err) begin
                            state <= RESP;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (req_size == 2'b10) begin
                            mem_wdata <= req_wdata;
                            state     <= WRITE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    rsp_rdata <= extract(mem_rdata, addr_q[1:0],
                                         size_q, uns_q);
                    state     <= RESP;
                end
                RMW_RD: begin
                    mem_wdata <= merge(mem_rdata, wdata_q,
                                       addr_q[1:0], size_q);
                    state     <= WRITE;
                end
                WRITE: state <= RESP;
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register, so an
    // async reset removes the write enable at once.
    always_comb begin
        req_ready   = (state == IDLE);
        rsp_valid   = (state == RESP);
        mem_ce      = (state == LOAD) || (state == RMW_RD)
                   || (state == WRITE);
        mem_data_le = (state == WRITE);
        mem_address = {addr_q[31:2], 2'b00};
    end

    logic unused;
    assign unused = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte RAM model.
// A second instance with a 28-byte RAM covers the range edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid2 = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_ready = 1'b0;
    logic        rsp_ready2 = 1'b0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_ce, mem_data_le;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic        req_ready2, rsp_valid2, rsp_err2;
    logic [31:0] rsp_rdata2;
    logic        mem_ce2, mem_data_le2;
    logic [31:0] mem_address2, mem_wdata2;
    logic [31:0] mem_rdata2 = 32'h0;

    logic [7:0] ram [0:31] = '{default: 8'h00};
    int ce_cnt = 0;
    int le_cnt = 0;
    int ce2_cnt = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_ce(mem_ce), .mem_data_le(mem_data_le),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.MEM_BYTES(28)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
        .mem_ce(mem_ce2), .mem_data_le(mem_data_le2),
        .mem_address(mem_address2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2)
    );

    // Combinational big-endian RAM read.
    always_comb begin
        int a;
        a = int'(mem_address[4:0]);
        if (mem_address < 32'd32)
            mem_rdata = {ram[a], ram[a+1], ram[a+2], ram[a+3]};
        else
            mem_rdata = 32'h0;
    end

    // RAM write port and strobe counters.
    always @(posedge clk) begin
        if (mem_ce && mem_data_le && mem_address < 32'd32) begin
            ram[int'(mem_address[4:0])]   <= mem_wdata[31:24];
            ram[int'(mem_address[4:0])+1] <= mem_wdata[23:16];
            ram[int'(mem_address[4:0])+2] <= mem_wdata[15:8];
            ram[int'(mem_address[4:0])+3] <= mem_wdata[7:0];
        end
        if (mem_ce) ce_cnt <= ce_cnt + 1;
        if (mem_data_le) le_cnt <= le_cnt + 1;
        if (mem_ce2) ce2_cnt <= ce2_cnt + 1;
    end

    function automatic logic [31:0] ramw(input int a);
        return {ram[a], ram[a+1], ram[a+2], ram[a+3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic we,
                       input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int exp_lat, input logic [31:0] exp_rd,
                       input logic exp_err);
        int lat;
        int c0;
        int l0;
        c0 = ce_cnt;
        l0 = le_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_size = sz;
        req_unsigned = un;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        if (exp_err)
            chk({tag, "_ce"}, 32'(ce_cnt - c0), 32'd0);
        else if (we)
            chk({tag, "_le"}, 32'(le_cnt - l0), 32'd1);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        // Reset state
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_ce", 32'(mem_ce), 32'd0);
        chk("rst_mem_le", 32'(mem_data_le), 32'd0);
        chk("rst_mem_addr", mem_address, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store / load
        run("sw4", 1, 2'b10, 0, 32'd4, 32'hDEADBEEF, 2, 32'h0, 0);
        chk("ram4", ramw(4), 32'hDEADBEEF);
        run("lw4", 0, 2'b10, 0, 32'd4, 32'h0, 2, 32'hDEADBEEF, 0);

        // Read-modify-write
        run("sw8", 1, 2'b10, 0, 32'd8, 32'h11223344, 2, 32'h0, 0);
        run("sb10", 1, 2'b00, 0, 32'd10, 32'hFFFFFFAA, 3, 32'h0, 0);
        chk("ram8_sb", ramw(8), 32'h1122AA44);
        run("sh8", 1, 2'b01, 0, 32'd8, 32'hFFFF5566, 3, 32'h0, 0);
        chk("ram8_sh", ramw(8), 32'h5566AA44);

        // Extending loads
        run("sw12", 1, 2'b10, 0, 32'd12, 32'h80FF7F01, 2, 32'h0, 0);
        run("lb13", 0, 2'b00, 0, 32'd13, 32'h0, 2, 32'hFFFFFFFF, 0);
        run("lbu13", 0, 2'b00, 1, 32'd13, 32'h0, 2, 32'h000000FF, 0);
        run("lh12", 0, 2'b01, 0, 32'd12, 32'h0, 2, 32'hFFFF80FF, 0);
        run("lhu14", 0, 2'b01, 1, 32'd14, 32'h0, 2, 32'h00007F01, 0);
        run("lb14", 0, 2'b00, 0, 32'd14, 32'h0, 2, 32'h0000007F, 0);
        run("lw28", 0, 2'b10, 0, 32'd28, 32'h0, 2, 32'h0, 0);

        // Errors
        run("e_lh3", 0, 2'b01, 0, 32'd3, 32'h0, 1, 32'h0, 1);
        run("e_sw6", 1, 2'b10, 0, 32'd6, 32'h12345678, 1, 32'h0, 1);
        chk("ram4_e", ramw(4), 32'hDEADBEEF);
        run("e_sz3", 0, 2'b11, 0, 32'd0, 32'h0, 1, 32'h0, 1);
        run("e_lw32", 0, 2'b10, 0, 32'd32, 32'h0, 1, 32'h0, 1);

        // Range edge on the 28-byte instance
        @(negedge clk);
        req_valid2 = 1'b1;
        req_we = 1'b0;
        req_size = 2'b10;
        req_addr = 32'd28;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        chk("e28_valid", 32'(rsp_valid2), 32'd1);
        chk("e28_err", 32'(rsp_err2), 32'd1);
        chk("e28_rdata", rsp_rdata2, 32'h0);
        chk("e28_ce", 32'(ce2_cnt), 32'd0);
        @(negedge clk);
        rsp_ready2 = 1'b1;
        @(posedge clk);
        #1 rsp_ready2 = 1'b0;
        chk("e28_idle", 32'(req_ready2), 32'd1);

        // Response backpressure
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_size = 2'b10;
        req_addr = 32'd4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("hold_lat", 32'(lat), 32'd2);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'b10;
        req_addr = 32'd8;
        req_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("hold_err", 32'(rsp_err), 32'd0);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("hold_idle", 32'(req_ready), 32'd1);
        chk("hold_rspv", 32'(rsp_valid), 32'd0);
        chk("hold_ram8", ramw(8), 32'h5566AA44);

        // Reset during RMW read
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'b00;
        req_addr = 32'd9;
        req_wdata = 32'h00000099;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rmw_ce", 32'(mem_ce), 32'd1);
        chk("rmw_addr", mem_address, 32'd8);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_ce", 32'(mem_ce), 32'd0);
        chk("ar_le", 32'(mem_data_le), 32'd0);
        chk("ar_ready", 32'(req_ready), 32'd1);
        chk("ar_rspv", 32'(rsp_valid), 32'd0);
        chk("ar_addr", mem_address, 32'h0);
        chk("ar_wdata", mem_wdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("ar_ram8", ramw(8), 32'h5566AA44);
        run("post_rst", 0, 2'b10, 0, 32'd8, 32'h0, 2, 32'h5566AA44, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
